// File: rtl/mmio_timer_responder.sv
// MMIO responder for the CPU data bus: GPIO output register plus a prescaled
// down-counting timer with sticky expiry flag and level interrupt.
module mmio_timer_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        rd_valid,
  output logic        hit,
  output logic [15:0] gpio_out,
  output logic        irq
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [15:0]        led_q, led_d;
  logic [15:0]        load_q, load_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        dout_q, dout_d;
  logic               auto_q, auto_d;
  logic               irq_en_q, irq_en_d;
  logic               expired_q, expired_d;
  logic               rd_valid_q, rd_valid_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic [PRESC_W-1:0] pc_q, pc_d;

  logic [3:0]  off;
  logic        wr, rd, count_wr, raw_tick, tick, expire, clear;
  logic [15:0] rdata, presc_ext;

  assign hit      = (addr[15:4] == BASE_ADDR[15:4]);
  assign wr       = en & rw & hit;
  assign rd       = en & ~rw & hit;
  assign off      = addr[3:0];
  assign count_wr = wr && (off == 4'h3);
  assign raw_tick = (state_q == StRun) && (pc_q == prescale_q);

  always_comb begin
    presc_ext              = '0;
    presc_ext[PRESC_W-1:0] = prescale_q;
    rdata                  = '0;
    case (off)
      4'h0:    rdata = led_q;
      4'h1:    rdata = {13'd0, irq_en_q, auto_q, state_q == StRun};
      4'h2:    rdata = load_q;
      4'h3:    rdata = count_q;
      4'h4:    rdata = {15'd0, expired_q};
      4'h5:    rdata = presc_ext;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    load_d     = load_q;
    count_d    = count_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    expire     = 1'b0;
    clear      = 1'b0;

    // A COUNT write on a tick edge swallows the whole tick.
    tick = raw_tick & ~count_wr;
    if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        expire = 1'b1;
        if (auto_q) count_d = load_q;
        else        state_d = StIdle;
      end
    end

    // Bus writes are applied last so they override timer side effects.
    if (wr) begin
      case (off)
        4'h0: led_d = din;
        4'h1: begin
          state_d  = din[0] ? StRun : StIdle;
          auto_d   = din[1];
          irq_en_d = din[2];
        end
        4'h2: load_d = din;
        4'h3: count_d = din;
        4'h4: clear = din[0];
        4'h5: prescale_d = din[PRESC_W-1:0];
        default: ;
      endcase
    end

    expired_d = expire | (expired_q & ~clear);

    // Prescaler only runs across consecutive RUN cycles; any entry or exit restarts it.
    if (state_q == StRun && state_d == StRun) pc_d = raw_tick ? '0 : pc_q + PRESC_W'(1);
    else                                      pc_d = '0;

    rd_valid_d = rd;
    dout_d     = rd ? rdata : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      led_q      <= '0;
      load_q     <= '0;
      count_q    <= '0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      prescale_q <= '0;
      pc_q       <= '0;
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      load_q     <= load_d;
      count_q    <= count_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
      rd_valid_q <= rd_valid_d;
      dout_q     <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign gpio_out = led_q;
  assign irq      = expired_q & irq_en_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Self-checking bench for mmio_timer_responder: directed scenarios plus a
// randomized run compared against a rule-level model of the register map.
module tb_mmio_timer_responder;

  logic        clk = 1'b0;
  logic        rst, en, rw;
  logic [15:0] addr, din, dout, gpio_out;
  logic        rd_valid, hit, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_timer_responder #(
    .BASE_ADDR(16'hFF00),
    .PRESC_W  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rw      (rw),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .rd_valid(rd_valid),
    .hit     (hit),
    .gpio_out(gpio_out),
    .irq     (irq)
  );

  // Reference model state
  logic [15:0] m_led, m_load, m_count, m_dout;
  logic [7:0]  m_presc;
  logic        m_enable, m_auto, m_irqen, m_expired, m_rdv;
  int          m_pc;

  task automatic m_reset();
    m_led = 0; m_load = 0; m_count = 0; m_dout = 0; m_presc = 0;
    m_enable = 0; m_auto = 0; m_irqen = 0; m_expired = 0; m_rdv = 0; m_pc = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] o);
    case (o)
      4'h0:    return m_led;
      4'h1:    return {13'd0, m_irqen, m_auto, m_enable};
      4'h2:    return m_load;
      4'h3:    return m_count;
      4'h4:    return {15'd0, m_expired};
      4'h5:    return {8'd0, m_presc};
      default: return 16'h0000;
    endcase
  endfunction

  // Applies one clock edge of spec rules to the model, given the bus inputs.
  task automatic m_edge(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic        h, wr_c, set_exp, clr, n_enable, n_auto, n_irqen;
    logic [3:0]  o;
    logic [15:0] n_led, n_load, n_count;
    logic [7:0]  n_presc;
    int          n_pc;
    h = (a[15:4] == 12'hFF0);
    o = a[3:0];
    wr_c = e && w && h;
    n_led = m_led; n_load = m_load; n_count = m_count; n_presc = m_presc;
    n_enable = m_enable; n_auto = m_auto; n_irqen = m_irqen; n_pc = m_pc;
    set_exp = 0; clr = 0;
    if (e && !w && h) begin
      m_dout = m_read(o);
      m_rdv  = 1;
    end else begin
      m_rdv = 0;
    end
    if (m_enable) begin
      if (m_pc == int'(m_presc)) begin
        n_pc = 0;
        if (!(wr_c && o == 4'h3)) begin
          if (m_count > 0) n_count = m_count - 1;
          else begin
            set_exp = 1;
            if (m_auto) n_count = m_load;
            else        n_enable = 0;
          end
        end
      end else begin
        n_pc = m_pc + 1;
      end
    end
    if (wr_c) begin
      case (o)
        4'h0: n_led = d;
        4'h1: begin n_enable = d[0]; n_auto = d[1]; n_irqen = d[2]; end
        4'h2: n_load = d;
        4'h3: n_count = d;
        4'h4: clr = d[0];
        4'h5: n_presc = d[7:0];
        default: ;
      endcase
    end
    if (!m_enable || !n_enable) n_pc = 0;
    m_expired = set_exp ? 1'b1 : (clr ? 1'b0 : m_expired);
    m_led = n_led; m_load = n_load; m_count = n_count; m_presc = n_presc;
    m_enable = n_enable; m_auto = n_auto; m_irqen = n_irqen; m_pc = n_pc;
  endtask

  // One bus cycle: drive, advance the model and the DUT by one edge, settle.
  task automatic bus(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    en = e; rw = w; addr = a; din = d;
    m_edge(e, w, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; rw = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_valid, dout, gpio_out, irq} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got rd_valid=%b dout=%h gpio=%h irq=%b want all 0",
               rd_valid, dout, gpio_out, irq);
    end
    for (int i = 0; i < 6; i++) begin
      bus(1, 0, 16'hFF00 + 16'(i), 16'h0);
      checks++;
      if ({rd_valid, dout} !== {1'b1, 16'h0000}) begin
        errors++;
        $display("FAIL reset_read off=%0d got rd_valid=%b dout=%h want 1/0000", i, rd_valid, dout);
      end
    end
  endtask

  task automatic test_gpio();
    bus(1, 1, 16'hFF00, 16'hA5C3);
    checks++;
    if (gpio_out !== 16'hA5C3) begin
      errors++;
      $display("FAIL gpio_write got=%h want=a5c3", gpio_out);
    end
    bus(1, 0, 16'hFF00, 16'h0);
    checks++;
    if ({rd_valid, dout} !== {1'b1, 16'hA5C3}) begin
      errors++;
      $display("FAIL gpio_read got rd_valid=%b dout=%h want 1/a5c3", rd_valid, dout);
    end
    bus(0, 0, 16'h0, 16'h0);
    checks++;
    if ({rd_valid, dout} !== {1'b0, 16'hA5C3}) begin
      errors++;
      $display("FAIL dout_hold got rd_valid=%b dout=%h want 0/a5c3", rd_valid, dout);
    end
  endtask

  task automatic test_autoreload();
    logic [15:0] want;
    do_reset();
    bus(1, 1, 16'hFF02, 16'd3);
    bus(1, 1, 16'hFF03, 16'd3);
    bus(1, 1, 16'hFF05, 16'd0);
    bus(1, 1, 16'hFF01, 16'h0007);
    for (int i = 0; i < 8; i++) begin
      bus(1, 0, 16'hFF03, 16'h0);
      want = 16'(3 - (i % 4));
      checks++;
      if ({rd_valid, dout} !== {1'b1, want}) begin
        errors++;
        $display("FAIL reload_count step=%0d got rd_valid=%b dout=%h want 1/%h",
                 i, rd_valid, dout, want);
      end
      checks++;
      if (irq !== (i >= 3)) begin
        errors++;
        $display("FAIL reload_irq step=%0d got=%b want=%b", i, irq, i >= 3);
      end
    end
    bus(1, 1, 16'hFF04, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL status_clear got irq=%b want 0", irq);
    end
    bus(0, 0, 16'h0, 16'h0);
    bus(0, 0, 16'h0, 16'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_quiet got irq=%b want 0", irq);
    end
    // Next expiry lands on this edge: the set must beat the clear.
    bus(1, 1, 16'hFF04, 16'h0001);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_expiry got irq=%b want 1", irq);
    end
    bus(1, 1, 16'hFF04, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL late_clear got irq=%b want 0", irq);
    end
  endtask

  task automatic test_oneshot();
    int  found;
    int  k;
    logic irq_seen;
    do_reset();
    bus(1, 1, 16'hFF03, 16'd2);
    bus(1, 1, 16'hFF05, 16'd4);
    bus(1, 1, 16'hFF01, 16'h0001);
    found = -1;
    k = 0;
    irq_seen = 0;
    while (found < 0 && k < 40) begin
      k++;
      bus(1, 0, 16'hFF04, 16'h0);
      if (irq !== 1'b0) irq_seen = 1;
      if (rd_valid === 1'b1 && dout[0] === 1'b1) found = k - 1;
    end
    checks++;
    if (found != 15) begin
      errors++;
      $display("FAIL oneshot_expiry got cycle=%0d want 15 (-1 = never)", found);
    end
    checks++;
    if (irq_seen) begin
      errors++;
      $display("FAIL oneshot_irq got irq high want low with irq_en=0");
    end
    bus(1, 0, 16'hFF01, 16'h0);
    checks++;
    if ({rd_valid, dout} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL oneshot_ctrl got rd_valid=%b dout=%h want 1/0000", rd_valid, dout);
    end
    bus(1, 0, 16'hFF03, 16'h0);
    checks++;
    if ({rd_valid, dout} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL oneshot_count got rd_valid=%b dout=%h want 1/0000", rd_valid, dout);
    end
  endtask

  task automatic test_unmapped();
    bus(1, 0, 16'h1234, 16'h0);
    checks++;
    if ({hit, rd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL miss_1234 got hit=%b rd_valid=%b want 0/0", hit, rd_valid);
    end
    bus(1, 1, 16'hFF0A, 16'hFFFF);
    checks++;
    if (hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_ff0a got=%b want=1", hit);
    end
    bus(1, 0, 16'hFF0A, 16'h0);
    checks++;
    if ({rd_valid, dout} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL reserved_read got rd_valid=%b dout=%h want 1/0000", rd_valid, dout);
    end
    checks++;
    if (gpio_out !== m_led) begin
      errors++;
      $display("FAIL reserved_write_gpio got=%h want=%h", gpio_out, m_led);
    end
  endtask

  task automatic test_random();
    logic        e, w, want_hit;
    logic [15:0] a, d;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        checks++;
        if ({rd_valid, dout, irq} !== 18'd0) begin
          errors++;
          $display("FAIL rand_reset n=%0d got rd_valid=%b dout=%h irq=%b want 0",
                   n, rd_valid, dout, irq);
        end
        continue;
      end
      e = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) != 0) a = 16'hFF00 | 16'($urandom_range(0, 15));
      else                           a = 16'($urandom);
      case (a[3:0])
        4'h2, 4'h3: d = 16'($urandom_range(0, 7));
        4'h5:       d = 16'($urandom_range(0, 3));
        default:    d = 16'($urandom);
      endcase
      bus(e, w, a, d);
      want_hit = (a[15:4] == 12'hFF0);
      checks++;
      if ({rd_valid, dout} !== {m_rdv, m_dout}) begin
        errors++;
        $display("FAIL rand_read n=%0d got rd_valid=%b dout=%h want %b/%h",
                 n, rd_valid, dout, m_rdv, m_dout);
      end
      checks++;
      if ({gpio_out, irq, hit} !== {m_led, m_expired & m_irqen, want_hit}) begin
        errors++;
        $display("FAIL rand_out n=%0d got gpio=%h irq=%b hit=%b want %h/%b/%b", n, gpio_out,
                 irq, hit, m_led, m_expired & m_irqen, want_hit);
      end
    end
  endtask

  initial begin
    rst = 1; en = 0; rw = 0; addr = 0; din = 0;
    m_reset();
    test_reset();
    test_gpio();
    test_autoreload();
    test_oneshot();
    test_unmapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
